// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter: one 2^k shift/rotate step per stage, global stall,
// sideband tag and illegal-op flag carried alongside each operation.
module pipe_shifter #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [2:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    typedef enum logic [2:0] {
        OP_SLL = 3'b000,
        OP_SRL = 3'b001,
        OP_SRA = 3'b010,
        OP_SLA = 3'b011,
        OP_ROL = 3'b100,
        OP_ROR = 3'b101
    } op_e;

    logic [WIDTH-1:0] data_q    [SHW];
    logic [WIDTH-1:0] data_d    [SHW];
    logic             carry_q   [SHW];
    logic             carry_d   [SHW];
    logic             valid_q   [SHW];
    logic             valid_d   [SHW];
    logic             illegal_q [SHW];
    logic             illegal_d [SHW];
    logic [2:0]       op_q      [SHW];
    logic [2:0]       op_d      [SHW];
    logic [SHW-1:0]   shamt_q   [SHW];
    logic [SHW-1:0]   shamt_d   [SHW];
    logic [TAG_W-1:0] tag_q     [SHW];
    logic [TAG_W-1:0] tag_d     [SHW];
    logic             zero_q;
    logic             zero_d;
    logic             stall;

    // Carry is the edge bit seen by the highest enabled stage; with stages applied
    // in ascending order this is original bit WIDTH-s (left) or s-1 (right).
    function automatic logic [WIDTH:0] shift_stage(
        input logic [WIDTH-1:0] x,
        input logic [2:0]       op,
        input logic             en,
        input int unsigned      k,
        input logic             cin
    );
        int unsigned             a;
        logic [SHW-1:0]          hi_i;
        logic [SHW-1:0]          lo_i;
        logic signed [WIDTH-1:0] xs;
        logic [WIDTH:0]          r;
        a    = 32'd1 << k;
        hi_i = SHW'(WIDTH - a);
        lo_i = SHW'(a - 1);
        xs   = x;
        r    = {cin, x};
        if (en) begin
            case (op)
                OP_SLL, OP_SLA: r = {x[hi_i], x << a};
                OP_SRL:         r = {x[lo_i], x >> a};
                OP_SRA:         r = {x[lo_i], xs >>> a};
                OP_ROL:         r = {x[hi_i], (x << a) | (x >> (WIDTH - a))};
                OP_ROR:         r = {x[lo_i], (x >> a) | (x << (WIDTH - a))};
                default:        r = {cin, x};
            endcase
        end
        return r;
    endfunction

    assign stall    = valid_q[SHW-1] & ~out_ready;
    assign in_ready = ~stall;

    always_comb begin
        valid_d[0]   = in_valid;
        op_d[0]      = in_op;
        shamt_d[0]   = in_shamt;
        tag_d[0]     = in_tag;
        illegal_d[0] = in_op[2] & in_op[1];
        {carry_d[0], data_d[0]} = shift_stage(in_data, in_op, in_shamt[0], 0, 1'b0);
        for (int unsigned k = 1; k < SHW; k++) begin
            valid_d[k]   = valid_q[k-1];
            op_d[k]      = op_q[k-1];
            shamt_d[k]   = shamt_q[k-1];
            tag_d[k]     = tag_q[k-1];
            illegal_d[k] = illegal_q[k-1];
            {carry_d[k], data_d[k]} = shift_stage(data_q[k-1], op_q[k-1],
                                                  shamt_q[k-1][k], k, carry_q[k-1]);
        end
        zero_d = (data_d[SHW-1] == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < SHW; k++) begin
                data_q[k]    <= '0;
                carry_q[k]   <= 1'b0;
                valid_q[k]   <= 1'b0;
                illegal_q[k] <= 1'b0;
                op_q[k]      <= '0;
                shamt_q[k]   <= '0;
                tag_q[k]     <= '0;
            end
            zero_q <= 1'b0;
        end else if (!stall) begin
            for (int unsigned k = 0; k < SHW; k++) begin
                data_q[k]    <= data_d[k];
                carry_q[k]   <= carry_d[k];
                valid_q[k]   <= valid_d[k];
                illegal_q[k] <= illegal_d[k];
                op_q[k]      <= op_d[k];
                shamt_q[k]   <= shamt_d[k];
                tag_q[k]     <= tag_d[k];
            end
            zero_q <= zero_d;
        end
    end

    assign out_valid   = valid_q[SHW-1];
    assign out_data    = data_q[SHW-1];
    assign out_carry   = carry_q[SHW-1];
    assign out_zero    = zero_q;
    assign out_illegal = illegal_q[SHW-1];
    assign out_tag     = tag_q[SHW-1];

endmodule

// File: tb/tb_pipe_shifter.sv
// Directed and randomised checks of pipe_shifter at WIDTH=32, TAG_W=4.
`timescale 1ns/1ps
module tb_pipe_shifter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic [2:0]  in_op;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_carry;
    logic        out_zero;
    logic        out_illegal;
    logic [3:0]  out_tag;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pop   = 0;

    typedef struct packed {
        logic [31:0] d;
        logic        c;
        logic        z;
        logic        il;
        logic [3:0]  t;
    } exp_t;

    exp_t sb_q[$];

    pipe_shifter #(.WIDTH(32), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_carry(out_carry), .out_zero(out_zero), .out_illegal(out_illegal),
        .out_tag(out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: direct formulas on the whole shift amount.
    function automatic exp_t ref_op(input logic [31:0] d, input logic [2:0] op,
                                    input logic [4:0] s, input logic [3:0] t);
        exp_t        e;
        logic [63:0] w;
        int          si;
        si   = int'(s);
        e.t  = t;
        e.il = 1'b0;
        e.c  = 1'b0;
        case (op)
            3'b000, 3'b011: begin
                e.d = d << si;
                if (si > 0) e.c = d[32 - si];
            end
            3'b001: begin
                e.d = d >> si;
                if (si > 0) e.c = d[si - 1];
            end
            3'b010: begin
                e.d = $signed(d) >>> si;
                if (si > 0) e.c = d[si - 1];
            end
            3'b100: begin
                w   = {d, d} << si;
                e.d = w[63:32];
                if (si > 0) e.c = d[32 - si];
            end
            3'b101: begin
                w   = {d, d} >> si;
                e.d = w[31:0];
                if (si > 0) e.c = d[si - 1];
            end
            default: begin
                e.d  = d;
                e.il = 1'b1;
            end
        endcase
        e.z = (e.d == 32'h0);
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 64'(sb_q.size()), 64'd1);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    n_pop++;
                    check("sb_data",    64'(out_data),    64'(e.d));
                    check("sb_carry",   64'(out_carry),   64'(e.c));
                    check("sb_zero",    64'(out_zero),    64'(e.z));
                    check("sb_illegal", 64'(out_illegal), 64'(e.il));
                    check("sb_tag",     64'(out_tag),     64'(e.t));
                end
            end
            if (in_valid && in_ready)
                sb_q.push_back(ref_op(in_data, in_op, in_shamt, in_tag));
        end
    end

    // Called at posedge+1; returns at posedge+1 after the result is consumed.
    task automatic run_one(input string nm, input logic [2:0] op, input logic [31:0] d,
                           input logic [4:0] s, input logic [3:0] t, input logic [31:0] ed,
                           input logic ec, input logic ez, input logic ei);
        int          lat;
        logic        v;
        logic [31:0] od;
        logic        oc, oz, oi;
        logic [3:0]  ot;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_op     = op;
        in_data   = d;
        in_shamt  = s;
        in_tag    = t;
        @(negedge clk);
        check({nm, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        v   = 1'b0;
        od = '0; oc = 1'b0; oz = 1'b0; oi = 1'b0; ot = '0;
        while (!v && lat < 20) begin
            @(negedge clk);
            v  = out_valid;
            od = out_data; oc = out_carry; oz = out_zero; oi = out_illegal; ot = out_tag;
            @(posedge clk);
            lat++;
        end
        #1;
        check({nm, "_latency"}, 64'(lat), 64'd5);
        check({nm, "_data"},    64'(od),  64'(ed));
        check({nm, "_carry"},   64'(oc),  64'(ec));
        check({nm, "_zero"},    64'(oz),  64'(ez));
        check({nm, "_illegal"}, 64'(oi),  64'(ei));
        check({nm, "_tag"},     64'(ot),  64'(t));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int          i_acc;
        int          n_acc;
        int          seen;
        int          pop0;
        logic [31:0] hd;
        logic [3:0]  ht;
        logic        hc;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_op     = '0;
        in_tag    = '0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_out_carry", 64'(out_carry), 64'd0);
        check("rst_out_zero",  64'(out_zero),  64'd0);
        check("rst_out_ill",   64'(out_illegal), 64'd0);
        check("rst_out_tag",   64'(out_tag),   64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // First request lands on the first edge after reset release.
        run_one("sra",   3'b010, 32'h8000_0000, 5'd4,  4'd3, 32'hF800_0000, 1'b0, 1'b0, 1'b0);
        run_one("sll",   3'b000, 32'h8000_0001, 5'd1,  4'd1, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
        run_one("srl",   3'b001, 32'h0000_000F, 5'd4,  4'd2, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
        run_one("ror",   3'b101, 32'h0000_0001, 5'd1,  4'd4, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
        run_one("sla0",  3'b011, 32'h1234_5678, 5'd0,  4'd5, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
        run_one("ill",   3'b111, 32'hDEAD_BEEF, 5'd7,  4'd6, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
        run_one("rol",   3'b100, 32'h8000_0000, 5'd1,  4'd7, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
        run_one("sra31", 3'b010, 32'h7FFF_FFFF, 5'd31, 4'd8, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
        run_one("rol8",  3'b100, 32'h1234_5678, 5'd8,  4'd9, 32'h3456_7812, 1'b0, 1'b0, 1'b0);
        run_one("srl16", 3'b001, 32'h0000_8000, 5'd16, 4'hA, 32'h0000_0000, 1'b1, 1'b1, 1'b0);

        // Back-to-back stream with a 3-cycle output stall.
        i_acc = 0;
        pop0  = n_pop;
        hd = '0; ht = '0; hc = 1'b0;
        for (int c = 0; c < 40; c++) begin
            out_ready = !(c >= 7 && c < 10);
            in_valid  = (i_acc < 8);
            in_op     = 3'(i_acc % 6);
            in_data   = 32'h8100_00F1 + (32'(i_acc) << 12);
            in_shamt  = 5'(i_acc * 5 + 1);
            in_tag    = 4'(i_acc);
            @(negedge clk);
            if (c >= 7 && c < 10) begin
                check("stall_in_ready",  64'(in_ready),  64'd0);
                check("stall_out_valid", 64'(out_valid), 64'd1);
                if (c == 7) begin
                    hd = out_data; ht = out_tag; hc = out_carry;
                end else begin
                    check("stall_hold_data",  64'(out_data),  64'(hd));
                    check("stall_hold_tag",   64'(out_tag),   64'(ht));
                    check("stall_hold_carry", 64'(out_carry), 64'(hc));
                end
            end
            if (c == 6 || c == 10) check("run_in_ready", 64'(in_ready), 64'd1);
            if (in_valid && in_ready) i_acc++;
            @(posedge clk);
            #1;
            if (c > 10 && i_acc == 8 && sb_q.size() == 0) break;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stall_accepted",  64'(i_acc),         64'd8);
        check("stall_delivered", 64'(n_pop - pop0),  64'd8);

        // Reset in flight: three requests accepted, then reset two cycles later.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_op    = 3'b000;
            in_data  = 32'h0000_0100 << i;
            in_shamt = 5'd2;
            in_tag   = 4'(i + 12);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready",  64'(in_ready),  64'd1);
        check("midrst_out_data",  64'(out_data),  64'd0);
        check("midrst_out_tag",   64'(out_tag),   64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
            @(posedge clk);
            #1;
        end
        check("midrst_no_stale", 64'(seen), 64'd0);
        run_one("post_rst", 3'b001, 32'hF000_0000, 5'd28, 4'hB, 32'h0000_000F, 1'b0, 1'b0, 1'b0);

        // Random traffic against the reference model under random out_ready.
        n_acc = 0;
        for (int c = 0; c < 60000 && n_acc < 10000; c++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_op     = 3'($urandom_range(0, 5));
            in_shamt  = 5'($urandom);
            in_data   = $urandom;
            in_tag    = 4'($urandom);
            @(negedge clk);
            if (in_valid && in_ready) n_acc++;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("rand_accepted", 64'(n_acc), 64'd10000);
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("rand_drained", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
